// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the immediate-extend stage.
package imm_ext_pkg;

  localparam int unsigned IMM_IN_W  = 16;
  localparam int unsigned IMM_OUT_W = 32;

  typedef enum logic [1:0] {
    IMM_ZERO  = 2'd0,
    IMM_SIGN  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_SHL2  = 2'd3
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_if.sv
// Valid/ready bus of the immediate-extend stage: upstream (data/mode/valid in) and downstream (data/valid out).
interface imm_ext_if
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = IMM_OUT_W
);

  logic [IN_W-1:0]  data_i;
  imm_mode_e        mode_i;
  logic             valid_i;
  logic             ready_o;
  logic [OUT_W-1:0] data_o;
  logic             valid_o;
  logic             ready_i;

  modport master (
    output data_i, mode_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );

  modport slave (
    input  data_i, mode_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );

endinterface

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender; shared by the pipelined and single-cycle datapaths.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = IMM_OUT_W
) (
  input  logic [IN_W-1:0]  data_i,
  input  imm_mode_e        mode_i,
  output logic [OUT_W-1:0] ext_c
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;

  always_comb begin
    sext  = {{PAD_W{data_i[IN_W-1]}}, data_i};
    ext_c = '0;
    case (mode_i)
      IMM_ZERO:  ext_c = {{PAD_W{1'b0}}, data_i};
      IMM_SIGN:  ext_c = sext;
      IMM_UPPER: ext_c = {data_i, {PAD_W{1'b0}}};
      IMM_SHL2:  ext_c = {sext[OUT_W-3:0], 2'b00};
      default:   ext_c = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extend stage with valid/ready handshake.
// Define IMM_EXT_SKID_EN for a 2-entry skid buffer with a registered ready_o.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = IMM_OUT_W
) (
  input  logic      clk_i,
  input  logic      rst_i,
  imm_ext_if.slave  bus
);

  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_extend_pipe: OUT_W must be >= IN_W+2");
  end

  logic [OUT_W-1:0] ext_c;
  logic [OUT_W-1:0] main_q, main_d;
  logic             main_v_q, main_v_d;
  logic             ready_c;
  logic             in_xfer_c, out_xfer_c;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .data_i (bus.data_i),
    .mode_i (bus.mode_i),
    .ext_c  (ext_c)
  );

`ifdef IMM_EXT_SKID_EN
  logic [OUT_W-1:0] skid_q, skid_d;
  logic             skid_v_q, skid_v_d;
  logic             ready_q;

  assign ready_c = ready_q;

  // Main register refills from skid first, so order is preserved across stalls.
  always_comb begin
    main_d     = main_q;
    main_v_d   = main_v_q;
    skid_d     = skid_q;
    skid_v_d   = skid_v_q;
    in_xfer_c  = bus.valid_i && ready_q;
    out_xfer_c = main_v_q && bus.ready_i;
    if (!main_v_q || out_xfer_c) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = in_xfer_c;
        if (in_xfer_c) main_d = ext_c;
      end
    end else if (in_xfer_c) begin
      skid_d   = ext_c;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      ready_q  <= !skid_v_d;
    end
  end
`else
  // Stall reaches upstream in the same cycle.
  assign ready_c = !main_v_q || bus.ready_i;

  always_comb begin
    main_d     = main_q;
    main_v_d   = main_v_q;
    in_xfer_c  = bus.valid_i && ready_c;
    out_xfer_c = main_v_q && bus.ready_i;
    if (in_xfer_c) begin
      main_d   = ext_c;
      main_v_d = 1'b1;
    end else if (out_xfer_c) begin
      main_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
    end
  end
`endif

  assign bus.ready_o = ready_c;
  assign bus.data_o  = main_q;
  assign bus.valid_o = main_v_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (IN_W=16, OUT_W=32): directed vectors plus a queue-based model.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;

  logic clk_i;
  logic rst_i;

  imm_ext_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int delivered = 0;
  logic [OUT_W-1:0] exp_q[$];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension from the mode definitions, as plain arithmetic on integers.
  function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] x, input imm_mode_e m);
    logic signed [OUT_W-1:0] s;
    s = OUT_W'($signed(x));
    case (m)
      IMM_ZERO:  return OUT_W'(x);
      IMM_SIGN:  return s;
      IMM_UPPER: return OUT_W'(x) << (OUT_W - IN_W);
      default:   return s << 2;
    endcase
  endfunction

  // Per-cycle compare; transfers are decided on inputs sampled here, which hold until after the next edge.
  always @(negedge clk_i) begin
    logic exp_v, exp_r;
    if (!rst_i) begin
      exp_q.delete();
      check("rst_valid_o", 64'(bus.valid_o), 64'(0));
      check("rst_data_o",  64'(bus.data_o),  64'(0));
      check("rst_ready_o", 64'(bus.ready_o), 64'(1));
    end else begin
      exp_v = (exp_q.size() > 0);
      check("valid_o", 64'(bus.valid_o), 64'(exp_v));
      if (exp_v) check("data_o", 64'(bus.data_o), 64'(exp_q[0]));
`ifdef IMM_EXT_SKID_EN
      exp_r = (exp_q.size() < 2);
`else
      exp_r = (exp_q.size() == 0) || bus.ready_i;
`endif
      check("ready_o", 64'(bus.ready_o), 64'(exp_r));
      if (exp_v && bus.ready_i) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (bus.valid_i && exp_r) exp_q.push_back(ref_ext(bus.data_i, bus.mode_i));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [IN_W-1:0]  vdat [8] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF,
                                 16'h4000, 16'h7FFF, 16'h0001, 16'hABCD};
  imm_mode_e        vmode[8] = '{IMM_SIGN, IMM_ZERO, IMM_UPPER, IMM_SHL2,
                                 IMM_SHL2, IMM_SIGN, IMM_SHL2, IMM_UPPER};
  logic [OUT_W-1:0] vexp [8] = '{32'hFFFF_8001, 32'h0000_8001, 32'h1234_0000, 32'hFFFF_FFFC,
                                 32'h0001_0000, 32'h0000_7FFF, 32'h0000_0004, 32'hABCD_0000};

  initial begin
    int k;
    int d0;
    int exp_k;
    bus.data_i  = '0;
    bus.mode_i  = IMM_ZERO;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    rst_i       = 1'b1;
    #2 rst_i    = 1'b0;

    // Pin the model against hand-computed values.
    for (int i = 0; i < 8; i++) check("model_pin", 64'(ref_ext(vdat[i], vmode[i])), 64'(vexp[i]));

    step(); step();
    rst_i = 1'b1;
    step();

    // Back-to-back directed vectors: each result appears one cycle after its accept.
    for (int i = 0; i < 8; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = vdat[i];
      bus.mode_i  = vmode[i];
      step();
      check("b2b_valid", 64'(bus.valid_o), 64'(1));
      check("b2b_data",  64'(bus.data_o),  64'(vexp[i]));
    end
    bus.valid_i = 1'b0;
    step(); step();
    check("idle_valid", 64'(bus.valid_o), 64'(0));

    // Stall with upstream pushing: count how many items the stage absorbs.
`ifdef IMM_EXT_SKID_EN
    exp_k = 2;
`else
    exp_k = 1;
`endif
    k  = 0;
    d0 = delivered;
    bus.ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = vdat[k];
      bus.mode_i  = vmode[k];
      @(negedge clk_i);
      if (bus.ready_o) k++;
      step();
    end
    check("stall_accepts", 64'(k), 64'(exp_k));
    check("stall_ready",   64'(bus.ready_o), 64'(0));
    check("stall_data",    64'(bus.data_o),  64'(vexp[0]));
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (4) step();
    check("drain_count", 64'(delivered - d0), 64'(exp_k));
    check("drain_valid", 64'(bus.valid_o), 64'(0));

    // Asynchronous reset in the middle of a stall with the stage full.
    bus.ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = vdat[c+3];
      bus.mode_i  = vmode[c+3];
      step();
    end
    check("pre_rst_valid", 64'(bus.valid_o), 64'(1));
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.valid_o), 64'(0));
    check("async_rst_data",  64'(bus.data_o),  64'(0));
    check("async_rst_ready", 64'(bus.ready_o), 64'(1));
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    step(); step();
    rst_i = 1'b1;
    step();
    check("post_rst_valid", 64'(bus.valid_o), 64'(0));

    // Random traffic; every cycle is checked against the model.
    for (int c = 0; c < 10000; c++) begin
      bus.valid_i = 1'($urandom_range(0, 1));
      bus.ready_i = ($urandom_range(0, 3) != 0);
      bus.data_i  = IN_W'($urandom);
      bus.mode_i  = imm_mode_e'($urandom_range(0, 3));
      step();
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (4) step();
    check("final_valid", 64'(bus.valid_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
